// File: rtl/pads_pwr_pkg.sv
// Shared types and helpers for the pad-ring power sequencer.
// Holds the state encoding, its width and the counter-width helper.
package pads_pwr_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    OFF       = 3'd0,
    WAIT_POC  = 3'd1,
    RAMP_UP   = 3'd2,
    SETTLE    = 3'd3,
    ON        = 3'd4,
    RAMP_DOWN = 3'd5,
    FAULT     = 3'd6
  } pwr_state_t;

  function automatic int cnt_width(input int stagger,
                                   input int settle);
    int m;
    m = (stagger > settle) ? stagger : settle;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/pads_pwr_sync.sv
// Multi-flop synchroniser with active-low async reset (resets to 0).
// Ports: clk, rst_n, d (async input), q (synchronised output).
module pads_pwr_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ff <= '0;
    else        ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/pads_pwr_seq.sv
// Pad-ring power sequencer: staggered group enable, settle, core reset release,
// reverse-order teardown and brown-out drop. Ports: clk, rst_n, pwr_req_i,
// poc_ok_i, grp_en_o, core_rst_no, pwr_ok_o, busy_o, state_o, fault_o.
// Optional POC watchdog: define PADS_PWR_SEQ_POC_WDOG_EN.
module pads_pwr_seq
  import pads_pwr_pkg::*;
#(
  parameter int N_GROUPS    = 4,
  parameter int STAGGER_CYC = 16,
  parameter int SETTLE_CYC  = 64,
  parameter int SYNC_STAGES = 2,
  parameter int POC_TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                pwr_req_i,
  input  logic                poc_ok_i,
  output logic [N_GROUPS-1:0] grp_en_o,
  output logic                core_rst_no,
  output logic                pwr_ok_o,
  output logic                busy_o,
  output logic [STATE_W-1:0]  state_o,
  output logic                fault_o
);

  localparam int CNT_W = cnt_width(STAGGER_CYC, SETTLE_CYC);
  localparam int IDX_W = $clog2(N_GROUPS + 1);
  localparam logic [CNT_W-1:0] STG_LAST = CNT_W'(STAGGER_CYC - 1);
  localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_FULL = IDX_W'(N_GROUPS);
  localparam logic [N_GROUPS-1:0] GRP_ONE = N_GROUPS'(1);

  logic poc_s;

  pads_pwr_sync #(.STAGES(SYNC_STAGES)) u_poc_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (poc_ok_i),
    .q     (poc_s)
  );

  pwr_state_t          state, state_n;
  logic [N_GROUPS-1:0] grp, grp_n;
  logic [IDX_W-1:0]    idx, idx_n;
  logic [CNT_W-1:0]    cnt, cnt_n;
  logic                rst_q, rst_q_n;
  logic                ok, ok_n;
  logic                flt, flt_n;

`ifdef PADS_PWR_SEQ_POC_WDOG_EN
  localparam int WD_W = $clog2(POC_TIMEOUT + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(POC_TIMEOUT - 1);
  logic [WD_W-1:0] wd, wd_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) wd <= '0;
    else        wd <= wd_n;
  end
`else
  logic unused_poc_timeout;
  assign unused_poc_timeout = ^POC_TIMEOUT;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= OFF;
      grp   <= '0;
      idx   <= '0;
      cnt   <= '0;
      rst_q <= 1'b0;
      ok    <= 1'b0;
      flt   <= 1'b0;
    end else begin
      state <= state_n;
      grp   <= grp_n;
      idx   <= idx_n;
      cnt   <= cnt_n;
      rst_q <= rst_q_n;
      ok    <= ok_n;
      flt   <= flt_n;
    end
  end

  always_comb begin
    state_n = state;
    grp_n   = grp;
    idx_n   = idx;
    cnt_n   = (cnt == '1) ? cnt : cnt + CNT_W'(1);
    rst_q_n = rst_q;
    ok_n    = ok;
    flt_n   = flt;
`ifdef PADS_PWR_SEQ_POC_WDOG_EN
    wd_n    = '0;
`endif
    unique case (state)
      OFF: begin
        if (pwr_req_i) state_n = WAIT_POC;
      end
      WAIT_POC: begin
`ifdef PADS_PWR_SEQ_POC_WDOG_EN
        wd_n = (wd == '1) ? wd : wd + WD_W'(1);
`endif
        if (!pwr_req_i) begin
          state_n = OFF;
        end else if (poc_s) begin
          // group 0 comes up on the very edge that enters RAMP_UP
          state_n = RAMP_UP;
          grp_n   = GRP_ONE;
          idx_n   = IDX_W'(1);
          cnt_n   = '0;
`ifdef PADS_PWR_SEQ_POC_WDOG_EN
        end else if (wd == WD_LAST) begin
          state_n = FAULT;
          grp_n   = '0;
          flt_n   = 1'b1;
`endif
        end
      end
      RAMP_UP, SETTLE, ON: begin
        if (!poc_s) begin
          // brown-out: drop everything at once, no stagger
          state_n = OFF;
          grp_n   = '0;
          idx_n   = '0;
          rst_q_n = 1'b0;
          ok_n    = 1'b0;
        end else if (!pwr_req_i) begin
          state_n = (idx == '0) ? OFF : RAMP_DOWN;
          cnt_n   = '0;
          rst_q_n = 1'b0;
          ok_n    = 1'b0;
        end else if (state == RAMP_UP && cnt == STG_LAST) begin
          cnt_n = '0;
          if (idx == IDX_FULL) begin
            state_n = SETTLE;
          end else begin
            grp_n = (grp << 1) | GRP_ONE;
            idx_n = idx + IDX_W'(1);
          end
        end else if (state == SETTLE && cnt == SET_LAST) begin
          state_n = ON;
          rst_q_n = 1'b1;
          ok_n    = 1'b1;
        end
      end
      RAMP_DOWN: begin
        // late pwr_req_i re-assertion is ignored until OFF
        if (idx == '0) begin
          state_n = OFF;
        end else if (cnt == STG_LAST) begin
          grp_n = grp >> 1;
          idx_n = idx - IDX_W'(1);
          cnt_n = '0;
        end
      end
      FAULT: begin
        if (!pwr_req_i) begin
          state_n = OFF;
          flt_n   = 1'b0;
        end
      end
      default: begin
        state_n = OFF;
        grp_n   = '0;
        idx_n   = '0;
        rst_q_n = 1'b0;
        ok_n    = 1'b0;
        flt_n   = 1'b0;
      end
    endcase
  end

  assign grp_en_o    = grp;
  assign core_rst_no = rst_q;
  assign pwr_ok_o    = ok;
  assign state_o     = state;
  assign busy_o      = !(state inside {OFF, ON, FAULT});
`ifdef PADS_PWR_SEQ_POC_WDOG_EN
  assign fault_o     = flt;
`else
  assign fault_o     = 1'b0;
`endif

endmodule

// File: tb/tb_pads_pwr_seq.sv
// Directed bench for pads_pwr_seq (N_GROUPS=4, STAGGER=3, SETTLE=5, SYNC=2).
// Covers bring-up, teardown, abort, brown-out, async reset and watchdog.
module tb_pads_pwr_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pwr_req;
  logic       poc_ok;
  logic [3:0] grp_en;
  logic       core_rst_n;
  logic       pwr_ok;
  logic       busy;
  logic [2:0] state;
  logic       fault;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  pads_pwr_seq #(
    .N_GROUPS    (4),
    .STAGGER_CYC (3),
    .SETTLE_CYC  (5),
    .SYNC_STAGES (2),
    .POC_TIMEOUT (20)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .pwr_req_i   (pwr_req),
    .poc_ok_i    (poc_ok),
    .grp_en_o    (grp_en),
    .core_rst_no (core_rst_n),
    .pwr_ok_o    (pwr_ok),
    .busy_o      (busy),
    .state_o     (state),
    .fault_o     (fault)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".state"}, 32'(state), 32'd0);
    chk({tag, ".grp"}, 32'(grp_en), 32'h0);
    chk({tag, ".crst"}, 32'(core_rst_n), 32'd0);
    chk({tag, ".ok"}, 32'(pwr_ok), 32'd0);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".fault"}, 32'(fault), 32'd0);
  endtask

  initial begin
    rst_n   = 1'b0;
    pwr_req = 1'b0;
    poc_ok  = 1'b0;
    ticks(3);
    chk_reset("rst");
    rst_n = 1'b1;
    ticks(2);
    chk("idle.state", 32'(state), 32'd0);

    // bring-up: WAIT_POC, then RAMP_UP once poc_s rises (T)
    pwr_req = 1'b1;
    poc_ok  = 1'b1;
    ticks(1);
    chk("up.wait", 32'(state), 32'd1);
    chk("up.busy", 32'(busy), 32'd1);
    ticks(2);
    chk("up.T.state", 32'(state), 32'd2);
    chk("up.T.grp", 32'(grp_en), 32'h1);
    ticks(2);
    chk("up.T2.grp", 32'(grp_en), 32'h1);
    ticks(1);
    chk("up.T3.grp", 32'(grp_en), 32'h3);
    ticks(3);
    chk("up.T6.grp", 32'(grp_en), 32'h7);
    ticks(3);
    chk("up.T9.grp", 32'(grp_en), 32'hf);
    ticks(2);
    chk("up.T11.state", 32'(state), 32'd2);
    ticks(1);
    chk("up.T12.state", 32'(state), 32'd3);
    ticks(4);
    chk("up.T16.crst", 32'(core_rst_n), 32'd0);
    chk("up.T16.state", 32'(state), 32'd3);
    ticks(1);
    chk("up.T17.state", 32'(state), 32'd4);
    chk("up.T17.crst", 32'(core_rst_n), 32'd1);
    chk("up.T17.ok", 32'(pwr_ok), 32'd1);
    chk("up.T17.busy", 32'(busy), 32'd0);

    // power-down from ON (D)
    pwr_req = 1'b0;
    ticks(1);
    chk("dn.D.state", 32'(state), 32'd5);
    chk("dn.D.crst", 32'(core_rst_n), 32'd0);
    chk("dn.D.ok", 32'(pwr_ok), 32'd0);
    chk("dn.D.grp", 32'(grp_en), 32'hf);
    ticks(2);
    chk("dn.D2.grp", 32'(grp_en), 32'hf);
    ticks(1);
    chk("dn.D3.grp", 32'(grp_en), 32'h7);
    ticks(3);
    chk("dn.D6.grp", 32'(grp_en), 32'h3);
    ticks(3);
    chk("dn.D9.grp", 32'(grp_en), 32'h1);
    ticks(3);
    chk("dn.D12.grp", 32'(grp_en), 32'h0);
    chk("dn.D12.state", 32'(state), 32'd5);
    ticks(1);
    chk("dn.D13.state", 32'(state), 32'd0);

    // abort mid-ramp at 0011; re-request during teardown is ignored
    pwr_req = 1'b1;
    ticks(1);
    chk("ab.wait", 32'(state), 32'd1);
    ticks(1);
    chk("ab.T.state", 32'(state), 32'd2);
    ticks(3);
    chk("ab.T3.grp", 32'(grp_en), 32'h3);
    pwr_req = 1'b0;
    ticks(1);
    chk("ab.D.state", 32'(state), 32'd5);
    chk("ab.D.grp", 32'(grp_en), 32'h3);
    pwr_req = 1'b1;
    ticks(3);
    chk("ab.D3.grp", 32'(grp_en), 32'h1);
    chk("ab.D3.state", 32'(state), 32'd5);
    chk("ab.D3.crst", 32'(core_rst_n), 32'd0);
    ticks(3);
    chk("ab.D6.grp", 32'(grp_en), 32'h0);
    ticks(1);
    chk("ab.D7.state", 32'(state), 32'd0);
    chk("ab.D7.crst", 32'(core_rst_n), 32'd0);
    ticks(1);
    chk("ab.rereq", 32'(state), 32'd1);
    ticks(1);
    chk("ab.T'.state", 32'(state), 32'd2);
    ticks(17);
    chk("ab.on.state", 32'(state), 32'd4);
    chk("ab.on.ok", 32'(pwr_ok), 32'd1);

    // brown-out in ON
    poc_ok = 1'b0;
    ticks(2);
    chk("bo.sync.state", 32'(state), 32'd4);
    ticks(1);
    chk("bo.state", 32'(state), 32'd0);
    chk("bo.grp", 32'(grp_en), 32'h0);
    chk("bo.crst", 32'(core_rst_n), 32'd0);
    chk("bo.ok", 32'(pwr_ok), 32'd0);
    ticks(1);
    chk("bo.rewait", 32'(state), 32'd1);

    // async reset between edges mid RAMP_UP
    poc_ok = 1'b1;
    ticks(2);
    chk("ar.wait", 32'(state), 32'd1);
    ticks(1);
    chk("ar.T.state", 32'(state), 32'd2);
    ticks(4);
    chk("ar.T4.grp", 32'(grp_en), 32'h3);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset("ar");
    poc_ok = 1'b0;
    ticks(1);
    rst_n = 1'b1;

    // POC watchdog (pwr_req=1, poc_ok=0)
    ticks(1);
    chk("wd.W.state", 32'(state), 32'd1);
`ifdef PADS_PWR_SEQ_POC_WDOG_EN
    ticks(19);
    chk("wd.W19.state", 32'(state), 32'd1);
    chk("wd.W19.fault", 32'(fault), 32'd0);
    ticks(1);
    chk("wd.W20.state", 32'(state), 32'd6);
    chk("wd.W20.fault", 32'(fault), 32'd1);
    chk("wd.W20.grp", 32'(grp_en), 32'h0);
    chk("wd.W20.busy", 32'(busy), 32'd0);
`else
    ticks(25);
    chk("wd.hold.state", 32'(state), 32'd1);
    chk("wd.hold.fault", 32'(fault), 32'd0);
    chk("wd.hold.busy", 32'(busy), 32'd1);
`endif
    pwr_req = 1'b0;
    ticks(1);
    chk("wd.off.state", 32'(state), 32'd0);
    chk("wd.off.fault", 32'(fault), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
